// File: rtl/divider_defs_pkg.sv
// Shared divider definitions: FSM state encoding and the DIV-op selects used by the ALU decoder.
// No logic; constants and types only.
package divider_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Decoder-side op select for DIV/DIVU/REM/REMU
  localparam logic [1:0] DIV_OP_DIV  = 2'd0;
  localparam logic [1:0] DIV_OP_DIVU = 2'd1;
  localparam logic [1:0] DIV_OP_REM  = 2'd2;
  localparam logic [1:0] DIV_OP_REMU = 2'd3;

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division step: shift in the next dividend bit, subtract divisor if it fits.
// Latency: combinational. Backpressure: none.
// Flow: none; evaluated once per CALC cycle by seq_divider.
module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   rem,
  input  logic                  dvd_msb,
  input  logic [DATA_WIDTH-1:0] dsr,
  output logic [DATA_WIDTH:0]   next_rem,
  output logic                  q_bit
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] diff;

  assign shifted = {rem[DATA_WIDTH-1:0], dvd_msb};
  assign diff    = shifted - {1'b0, dsr};
  // A set top bit means the true shifted value exceeds any W-bit divisor.
  assign q_bit    = rem[DATA_WIDTH] | (shifted >= {1'b0, dsr});
  assign next_rem = q_bit ? diff : shifted;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider with RV32M DIV/DIVU/REM/REMU semantics.
// Latency: DATA_WIDTH+1 cycles from accepted start to done (1 cycle for divide-by-zero).
// Backpressure: busy=1 while working; start is ignored whenever busy is high.
module seq_divider
  import divider_defs::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero
);

  localparam int CW = $clog2(DATA_WIDTH);

  div_state_t            state, state_nxt;
  logic                  accept;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] dvd, dsr, q, raw_dvd;
  logic [DATA_WIDTH:0]   rem;
  logic [DATA_WIDTH:0]   next_rem;
  logic                  q_bit;
  logic                  neg_q, neg_r, dz;
  logic [DATA_WIDTH-1:0] dvd_mag, dsr_mag;

  assign dvd_mag = (is_signed && dividend[DATA_WIDTH-1]) ? -dividend : dividend;
  assign dsr_mag = (is_signed && divisor[DATA_WIDTH-1])  ? -divisor  : divisor;

  div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem      (rem),
    .dvd_msb  (dvd[DATA_WIDTH-1]),
    .dsr      (dsr),
    .next_rem (next_rem),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // done is registered, so the cycle it is high the FSM already sits in IDLE;
  // gating accept on done keeps start in that cycle from being taken.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = (state != IDLE) || done;
    case (state)
      IDLE: begin
        if (start && !done) begin
          accept    = 1'b1;
          state_nxt = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt         <= '0;
      dvd         <= '0;
      dsr         <= '0;
      q           <= '0;
      rem         <= '0;
      raw_dvd     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dvd     <= dvd_mag;
            dsr     <= dsr_mag;
            raw_dvd <= dividend;
            q       <= '0;
            rem     <= '0;
            cnt     <= CW'(DATA_WIDTH - 1);
            neg_q   <= is_signed & (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
            neg_r   <= is_signed & dividend[DATA_WIDTH-1];
            dz      <= (divisor == '0);
          end
        end
        CALC: begin
          rem <= next_rem;
          q   <= {q[DATA_WIDTH-2:0], q_bit};
          dvd <= {dvd[DATA_WIDTH-2:0], 1'b0};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        DONE: begin
          // MIN/-1 lands here as q=2^(W-1) with neg_q=0, which is already MIN.
          done        <= 1'b1;
          div_by_zero <= dz;
          quotient    <= dz ? '1 : (neg_q ? -q : q);
          remainder   <= dz ? raw_dvd
                            : (neg_r ? -rem[DATA_WIDTH-1:0] : rem[DATA_WIDTH-1:0]);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (W=32): vector table plus hand sequences,
// with a scoreboard queue popped on every done pulse.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  seq_divider #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
    int          acc;
  } vec_t;

  vec_t sb[$];
  vec_t vecs[12];
  int   compared = 0;
  int   failed   = 0;
  int   cyc      = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] q, input logic [31:0] r, input logic dz);
    vec_t v;
    v.sgn = sgn; v.a = a; v.b = b; v.q = q; v.r = r; v.dz = dz;
    v.lat = dz ? 1 : 33;
    v.acc = 0;
    return v;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rstn === 1'b1 && done === 1'b1) begin
      vec_t e;
      chk("done_single_pulse", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        compared++;
        failed++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
    prev_done = done;
  end

  task automatic issue(input vec_t v, input bit push, output int acc);
    @(negedge clk);
    is_signed = v.sgn;
    dividend  = v.a;
    divisor   = v.b;
    start     = 1'b1;
    acc       = cyc + 1;
    v.acc     = acc;
    if (push) sb.push_back(v);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      compared++;
      failed++;
      $display("FAIL wait_idle: got busy=%0b pending=%0d expected idle", busy, sb.size());
    end
  endtask

  initial begin
    int   acc;
    vec_t v;
    logic [31:0] a, b;

    rstn = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dz", {31'd0, div_by_zero}, 32'd0);
    rstn = 1'b1;

    vecs[0]  = mk(0, 32'd100,        32'd7,          32'd14,         32'd2,          0);
    vecs[1]  = mk(1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   0);
    vecs[2]  = mk(1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          0);
    vecs[3]  = mk(0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1);
    vecs[4]  = mk(1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1);
    vecs[5]  = mk(0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          0);
    vecs[6]  = mk(1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          0);
    vecs[7]  = mk(1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   0);
    vecs[8]  = mk(0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          0);
    vecs[9]  = mk(0, 32'd3,          32'd10,         32'd0,          32'd3,          0);
    vecs[10] = mk(1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9,   1);
    vecs[11] = mk(0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   0);

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i], 1, acc);
      wait_idle();
    end

    // Second start mid-divide must be ignored.
    issue(vecs[0], 1, acc);
    while (cyc != acc + 9) @(negedge clk);
    is_signed = 1'b0; dividend = 32'd999; divisor = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_ignored_start", {31'd0, busy}, 32'd1);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("held_quotient", quotient, 32'd14);
    chk("held_remainder", remainder, 32'd2);
    chk("idle_after_ignored", {31'd0, busy}, 32'd0);

    // Start raised during the done cycle is taken one cycle later.
    issue(vecs[0], 1, acc);
    for (int i = 0; i < 60 && done !== 1'b1; i++) @(negedge clk);
    v = mk(0, 32'd1000, 32'd10, 32'd100, 32'd0, 0);
    is_signed = v.sgn; dividend = v.a; divisor = v.b; start = 1'b1;
    v.acc = cyc + 2;
    sb.push_back(v);
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset in the middle of a divide aborts it with no done.
    issue(mk(0, 32'd123456, 32'd789, 32'd0, 32'd0, 0), 0, acc);
    while (cyc != acc + 14) @(negedge clk);
    chk("busy_before_abort", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    chk("abort_dz", {31'd0, div_by_zero}, 32'd0);
    repeat (40) @(negedge clk);
    issue(vecs[1], 1, acc);
    wait_idle();

    // Random operands checked against the language's own / and %.
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = (i % 4 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      if (b == 32'd0) b = 32'd1;
      if (i % 2 == 0) begin
        v = mk(0, a, b, a / b, a % b, 0);
      end else begin
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
        v = mk(1, a, b, 32'($signed(a) / $signed(b)), 32'($signed(a) % $signed(b)), 0);
      end
      issue(v, 1, acc);
      wait_idle();
    end

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
